// File: rtl/uart_frame_ctrl.sv
// UART frame receiver: HEADER, 8 payload bytes, XOR checksum byte.
// Delivers the 64-bit payload on a good checksum and reports checksum/timeout errors.
module uart_frame_ctrl #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  uart_data_out,
  input  logic        uart_done,
  output logic [63:0] data_64,
  output logic        data_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  localparam int TMO_BITS = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TMO_W    = (TMO_BITS > 16) ? TMO_BITS : 16;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  logic [1:0]       state_r, state_nxt_s;
  logic [63:0]      shift_r, shift_nxt_s;
  logic [7:0]       xor_r, xor_nxt_s;
  logic [2:0]       byte_cnt_r, byte_cnt_nxt_s;
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_nxt_s;
  logic [1:0]       err_code_nxt_s;
  logic             good_s;
  logic             err_s;
  logic             tmo_hit_s;

  // uart_done wins over an expiry landing on the same cycle
  assign tmo_hit_s = (tmo_cnt_r == TMO_LAST) && !uart_done;

  assign busy = (state_r != ST_IDLE);

  // Next-state, datapath and error decision for the frame parser
  always_comb begin
    state_nxt_s    = state_r;
    shift_nxt_s    = shift_r;
    xor_nxt_s      = xor_r;
    byte_cnt_nxt_s = byte_cnt_r;
    tmo_cnt_nxt_s  = tmo_cnt_r;
    err_code_nxt_s = err_code;
    good_s         = 1'b0;
    err_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tmo_cnt_nxt_s = TMO_ZERO;
        if (uart_done && (uart_data_out == HEADER)) begin
          byte_cnt_nxt_s = 3'd0;
          xor_nxt_s      = 8'h00;
          state_nxt_s    = ST_PAYLOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (uart_done) begin
          shift_nxt_s    = {shift_r[55:0], uart_data_out};
          xor_nxt_s      = csum_fold(xor_r, uart_data_out);
          byte_cnt_nxt_s = byte_cnt_r + 3'd1;
          tmo_cnt_nxt_s  = TMO_ZERO;
          if (byte_cnt_r == 3'd7) begin
            state_nxt_s = ST_CHECK;
          end else begin
            state_nxt_s = ST_PAYLOAD;
          end
        end else if (tmo_hit_s) begin
          state_nxt_s    = ST_IDLE;
          tmo_cnt_nxt_s  = TMO_ZERO;
          err_s          = 1'b1;
          err_code_nxt_s = ERR_TMO;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TMO_ONE;
        end
      end
      ST_CHECK: begin
        if (uart_done) begin
          tmo_cnt_nxt_s = TMO_ZERO;
          state_nxt_s   = ST_IDLE;
          if (uart_data_out == xor_r) begin
            good_s         = 1'b1;
            err_code_nxt_s = ERR_NONE;
          end else begin
            err_s          = 1'b1;
            err_code_nxt_s = ERR_CSUM;
          end
        end else if (tmo_hit_s) begin
          state_nxt_s    = ST_IDLE;
          tmo_cnt_nxt_s  = TMO_ZERO;
          err_s          = 1'b1;
          err_code_nxt_s = ERR_TMO;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TMO_ONE;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        tmo_cnt_nxt_s  = TMO_ZERO;
        byte_cnt_nxt_s = 3'd0;
        xor_nxt_s      = 8'h00;
      end
    endcase
  end

  // State, datapath and registered output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      shift_r    <= 64'h0;
      xor_r      <= 8'h00;
      byte_cnt_r <= 3'd0;
      tmo_cnt_r  <= TMO_ZERO;
      data_64    <= 64'h0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      frame_cnt  <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      shift_r    <= shift_nxt_s;
      xor_r      <= xor_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
      tmo_cnt_r  <= tmo_cnt_nxt_s;
      data_valid <= good_s;
      frame_err  <= err_s;
      err_code   <= err_code_nxt_s;
      if (good_s) begin
        data_64   <= shift_r;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        data_64   <= data_64;
        frame_cnt <= frame_cnt;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: good/bad frames, timeout, noise,
// expiry collision, mid-frame reset and frame counter wrap.
module tb_uart_frame_ctrl;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  uart_data_out = 8'h00;
  logic        uart_done = 1'b0;
  logic [63:0] data_64;
  logic        data_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [7:0]  frame_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int exp_dv = 0;
  int exp_fe = 0;

  uart_frame_ctrl #(.HEADER(8'hA5), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .uart_data_out(uart_data_out), .uart_done(uart_done),
    .data_64(data_64), .data_valid(data_valid), .frame_err(frame_err),
    .err_code(err_code), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (data_valid) dv_cnt <= dv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_data_out = b;
    uart_done = 1'b1;
    @(negedge clk);
    uart_done = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] p, input logic [7:0] cs);
    send_byte(8'hA5);
    for (int i = 7; i >= 0; i--) send_byte(p[i*8 +: 8]);
    send_byte(cs);
  endtask

  initial begin
    idle(2);
    chk("rst_data", data_64, 64'h0);
    chk("rst_dv", {63'h0, data_valid}, 64'h0);
    chk("rst_fe", {63'h0, frame_err}, 64'h0);
    chk("rst_code", {62'h0, err_code}, 64'h0);
    chk("rst_cnt", {56'h0, frame_cnt}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    rst_n = 1'b1;
    idle(1);

    // Good frame
    send_byte(8'hA5);
    chk("hdr_busy", {63'h0, busy}, 64'h1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11));
    chk("good_no_dv_yet", {63'h0, data_valid}, 64'h0);
    send_byte(8'h88);
    chk("good_dv", {63'h0, data_valid}, 64'h1);
    chk("good_data", data_64, 64'h1122334455667788);
    chk("good_cnt", {56'h0, frame_cnt}, 64'h1);
    chk("good_code", {62'h0, err_code}, 64'h0);
    chk("good_busy", {63'h0, busy}, 64'h0);
    idle(1);
    chk("good_dv_drop", {63'h0, data_valid}, 64'h0);
    idle(1);
    exp_dv++;
    chk("good_dv_pulses", 64'(dv_cnt), 64'(exp_dv));

    // Bad checksum
    send_frame(64'h1122334455667788, 8'h00);
    chk("bad_fe", {63'h0, frame_err}, 64'h1);
    chk("bad_code", {62'h0, err_code}, 64'h1);
    chk("bad_data", data_64, 64'h1122334455667788);
    chk("bad_cnt", {56'h0, frame_cnt}, 64'h1);
    idle(1);
    chk("bad_fe_drop", {63'h0, frame_err}, 64'h0);
    idle(1);
    exp_fe++;
    chk("bad_fe_pulses", 64'(fe_cnt), 64'(exp_fe));
    chk("bad_dv_pulses", 64'(dv_cnt), 64'(exp_dv));

    // Timeout: expiry fires on the T-th edge after the last byte
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(T - 1);
    chk("tmo_early_busy", {63'h0, busy}, 64'h1);
    chk("tmo_early_fe", {63'h0, frame_err}, 64'h0);
    idle(1);
    chk("tmo_fe", {63'h0, frame_err}, 64'h1);
    chk("tmo_code", {62'h0, err_code}, 64'h2);
    chk("tmo_busy", {63'h0, busy}, 64'h0);
    chk("tmo_data", data_64, 64'h1122334455667788);
    idle(2);
    exp_fe++;
    chk("tmo_fe_pulses", 64'(fe_cnt), 64'(exp_fe));
    send_frame(64'h0102030405060708, 8'h08);
    chk("after_tmo_dv", {63'h0, data_valid}, 64'h1);
    chk("after_tmo_data", data_64, 64'h0102030405060708);
    chk("after_tmo_code", {62'h0, err_code}, 64'h0);
    chk("after_tmo_cnt", {56'h0, frame_cnt}, 64'h2);
    exp_dv++;

    // Noise before header, header value inside payload
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("noise_busy", {63'h0, busy}, 64'h0);
    send_frame(64'h1020A53040506070, 8'hA5);
    chk("hdrdata_dv", {63'h0, data_valid}, 64'h1);
    chk("hdrdata_data", data_64, 64'h1020A53040506070);
    chk("hdrdata_cnt", {56'h0, frame_cnt}, 64'h3);
    exp_dv++;

    // uart_done on the exact expiry cycle
    send_byte(8'hA5);
    send_byte(8'h11);
    idle(T - 2);
    send_byte(8'h22);
    chk("coll_fe", {63'h0, frame_err}, 64'h0);
    chk("coll_busy", {63'h0, busy}, 64'h1);
    for (int i = 3; i <= 8; i++) send_byte(8'(i * 8'h11));
    send_byte(8'h88);
    chk("coll_dv", {63'h0, data_valid}, 64'h1);
    chk("coll_cnt", {56'h0, frame_cnt}, 64'h4);
    exp_dv++;
    idle(2);
    chk("coll_fe_pulses", 64'(fe_cnt), 64'(exp_fe));
    chk("coll_dv_pulses", 64'(dv_cnt), 64'(exp_dv));

    // Reset after byte 5 of a frame
    send_byte(8'hA5);
    for (int i = 1; i <= 5; i++) send_byte(8'(i * 8'h11));
    rst_n = 1'b0;
    #1;
    chk("mrst_data", data_64, 64'h0);
    chk("mrst_cnt", {56'h0, frame_cnt}, 64'h0);
    chk("mrst_code", {62'h0, err_code}, 64'h0);
    chk("mrst_busy", {63'h0, busy}, 64'h0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("mrst_dv_pulses", 64'(dv_cnt), 64'(exp_dv));
    chk("mrst_fe_pulses", 64'(fe_cnt), 64'(exp_fe));
    send_frame(64'h1122334455667788, 8'h88);
    chk("mrst_next_dv", {63'h0, data_valid}, 64'h1);
    chk("mrst_next_data", data_64, 64'h1122334455667788);
    chk("mrst_next_cnt", {56'h0, frame_cnt}, 64'h1);
    exp_dv++;

    // 256 good frames since reset wrap the counter
    repeat (254) send_frame(64'h0102030405060708, 8'h08);
    chk("wrap_ff", {56'h0, frame_cnt}, 64'hFF);
    send_frame(64'h1122334455667788, 8'h88);
    chk("wrap_00", {56'h0, frame_cnt}, 64'h0);
    idle(2);
    exp_dv += 255;
    chk("wrap_dv_pulses", 64'(dv_cnt), 64'(exp_dv));
    chk("wrap_fe_pulses", 64'(fe_cnt), 64'(exp_fe));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
